astable_555_core: RTL

// - Fixed-point discrete-time model of a 555 timer in astable mode, driven by its control-voltage pin.
// - It is the consumer of v_control, the control voltage node from the walk-enable network.
// - It produces square_wave, which feeds back into that network.
// - Integrates the timing-capacitor node one step per step_en and switches on threshold crossings.
// - Output thresholds: upper = v_control, lower = v_control/2.
// - Reports the oscillation period in steps for audio/timing checks.

---
 rtl/astable_555_pkg.sv | 22 ++
 rtl/astable_555_core_rc_node_step.sv | 44 ++++
 rtl/astable_555_core.sv | 135 +++++++++++++
 3 files changed

// File: rtl/astable_555_pkg.sv
// ============================================================================
// Module   : astable_555_pkg
// Contents : Shared types and constants for the astable 555 timer model.
// Revision : 1.0
// ============================================================================
`default_nettype none

package astable_555_pkg;

   typedef logic [15:0] sample_t;

   typedef enum logic [0:0] {
      CHARGE    = 1'b0,
      DISCHARGE = 1'b1
   } state_e;

   localparam sample_t     FS      = 16'hFFFF;
   localparam int unsigned Q_SHIFT = 16;

endpackage

`default_nettype wire

// File: rtl/astable_555_core_rc_node_step.sv
// ============================================================================
// Module   : rc_node_step
// Contents : One combinational step of an RC node toward target or toward 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rc_node_step
   import astable_555_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] v_cap_i,
   input  logic [W-1:0] target_i,
   input  logic [W-1:0] k_i,
   input  logic         dir_i,
   output logic [W-1:0] v_next_o
);

   logic [W-1:0]   w_diff;
   logic [W-1:0]   w_d;
   logic [2*W-1:0] w_prod;
   logic           w_unused_lsb;

   // The step never exceeds the remaining distance (k < 1.0), so the
   // result is inherently saturated at target when charging and at 0 when discharging.
   always_comb begin
      w_diff = v_cap_i;
      if (dir_i) begin
         w_diff = (target_i > v_cap_i) ? (target_i - v_cap_i) : '0;
      end
      w_prod = {{W{1'b0}}, w_diff} * {{W{1'b0}}, k_i};
      w_d    = w_prod[Q_SHIFT +: W];
      if ((w_diff != '0) && (w_d == '0)) begin
         w_d = {{(W-1){1'b0}}, 1'b1};
      end
      v_next_o = dir_i ? (v_cap_i + w_d) : (v_cap_i - w_d);
   end

   assign w_unused_lsb = ^w_prod[Q_SHIFT-1:0];

endmodule

`default_nettype wire

// File: rtl/astable_555_core.sv
// ============================================================================
// Module   : astable_555_core
// Contents : Discrete-time 555 astable: cap integration, thresholds, period count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module astable_555_core
   import astable_555_pkg::*;
#(
   parameter int unsigned      W         = 16,
   parameter logic [W-1:0]     K_CHG     = 16'd655,
   parameter logic [W-1:0]     K_DIS     = 16'd1311,
   parameter logic [W-1:0]     MIN_VCTRL = 16'h0400,
   parameter int unsigned      PCNT_W    = 20
) (
   input  logic              clk_msdsl,
   input  logic              rst_msdsl_n,
   input  logic              step_en,
   input  logic [W-1:0]      vcc,
   input  logic [W-1:0]      v_control,
   input  logic              pin_reset_n,
   output logic [W-1:0]      square_wave,
   output logic              out_high,
   output logic [W-1:0]      v_cap,
   output logic [PCNT_W-1:0] period_steps,
   output logic              period_valid
);

   state_e              state_q, state_d;
   logic [W-1:0]        vcap_q, vcap_d;
   logic [W-1:0]        sq_q, sq_d;
   logic                high_q, high_d;
   logic [PCNT_W-1:0]   cnt_q, cnt_d;
   logic [PCNT_W-1:0]   per_q, per_d;
   logic                pv_q, pv_d;
   logic                seen_q, seen_d;

   logic [W-1:0]        w_vc;
   logic [W-1:0]        w_upper;
   logic [W-1:0]        w_lower;
   logic                w_dis;
   logic [W-1:0]        w_vnext;
   logic [PCNT_W-1:0]   w_cnt_inc;

   assign w_vc    = (v_control < MIN_VCTRL) ? MIN_VCTRL : v_control;
   assign w_upper = w_vc;
   assign w_lower = w_vc >> 1;

   // A low RESET pin discharges the cap immediately, even from CHARGE.
   assign w_dis = (state_q == DISCHARGE) || !pin_reset_n;

   rc_node_step #(
      .W (W)
   ) u_rc_node_step (
      .v_cap_i  (vcap_q),
      .target_i (vcc),
      .k_i      (w_dis ? K_DIS : K_CHG),
      .dir_i    (!w_dis),
      .v_next_o (w_vnext)
   );

   always_ff @(posedge clk_msdsl or negedge rst_msdsl_n) begin
      if (!rst_msdsl_n) begin
         state_q <= CHARGE;
         vcap_q  <= '0;
         sq_q    <= '0;
         high_q  <= 1'b0;
         cnt_q   <= '0;
         per_q   <= '0;
         pv_q    <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vcap_q  <= vcap_d;
         sq_q    <= sq_d;
         high_q  <= high_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         pv_q    <= pv_d;
         seen_q  <= seen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (step_en) begin
         if (!pin_reset_n) begin
            state_d = DISCHARGE;
         end else begin
            case (state_q)
               CHARGE:    if (w_vnext >= w_upper) state_d = DISCHARGE;
               DISCHARGE: if (w_vnext <= w_lower) state_d = CHARGE;
               default:   state_d = CHARGE;
            endcase
         end
      end
   end

   assign w_cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + 1'b1);

   always_comb begin
      vcap_d = vcap_q;
      sq_d   = sq_q;
      high_d = high_q;
      cnt_d  = cnt_q;
      per_d  = per_q;
      pv_d   = 1'b0;
      seen_d = seen_q;
      if (step_en) begin
         vcap_d = w_vnext;
         high_d = (state_d == CHARGE);
         sq_d   = high_d ? vcc : '0;
         cnt_d  = w_cnt_inc;
         // The first rise after reset only arms the counter; no prior rise to measure from.
         if ((state_q == DISCHARGE) && (state_d == CHARGE)) begin
            cnt_d  = '0;
            seen_d = 1'b1;
            if (seen_q) begin
               per_d = w_cnt_inc;
               pv_d  = 1'b1;
            end
         end
      end
   end

   assign square_wave  = sq_q;
   assign out_high     = high_q;
   assign v_cap        = vcap_q;
   assign period_steps = per_q;
   assign period_valid = pv_q;

endmodule

`default_nettype wire
